// File: rtl/pc_pkg.sv
// Shared op encoding for the program counter and its return stack.
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_INC  = 3'd0,
        PC_LD   = 3'd1,
        PC_BR   = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4,
        PC_HOLD = 3'd5
    } pc_op_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack; push on full and pop on empty are ignored.
module ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty
);

    localparam int SP_W  = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  cnt;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign full    = (cnt == SP_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign wr_idx  = IDX_W'(cnt);
    assign top_idx = IDX_W'(cnt - 1'b1);
    assign sp      = cnt;
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            cnt         <= cnt + 1'b1;
        end else if (pop && !empty) begin
            // clear the vacated slot so stale returns never resurface
            mem[top_idx] <= '0;
            cnt          <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with relative branch, stall and CALL/RET via ret_stack.
module pc_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [PC_OP_W-1:0]         op,
    input  logic [WIDTH-1:0]           addr,
    input  logic [WIDTH-1:0]           offset,
    output logic [WIDTH-1:0]           pc_out,
    output logic [WIDTH-1:0]           ret_top,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       ovf,
    output logic                       unf
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic             push;
    logic             pop;
    logic             set_ovf;
    logic             set_unf;
    logic             full;
    logic             empty;

    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        pc_d    = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (op)
            PC_LD:   pc_d = addr;
            PC_BR:   pc_d = pc_q + offset;
            PC_CALL: begin
                pc_d    = addr;
                push    = en && !full;
                set_ovf = full;
            end
            PC_RET: begin
                pc_d    = empty ? pc_inc : ret_top;
                pop     = en && !empty;
                set_unf = empty;
            end
            PC_HOLD: pc_d = pc_q;
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (en) begin
            pc_q <= pc_d;
            ovf  <= ovf | set_ovf;
            unf  <= unf | set_unf;
        end
    end

    assign pc_out = pc_q;

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (ret_top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (WIDTH=8, DEPTH=4).
module tb_pc_stack;
    import pc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [7:0] addr;
    logic [7:0] offset;
    logic [7:0] pc_out;
    logic [7:0] ret_top;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;

    int n_run  = 0;
    int n_fail = 0;

    pc_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .op      (op),
        .addr    (addr),
        .offset  (offset),
        .pc_out  (pc_out),
        .ret_top (ret_top),
        .sp      (sp),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] o,
                        input logic [7:0] a, input logic [7:0] f);
        en     = e;
        op     = o;
        addr   = a;
        offset = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b1, 3'd0, 8'h00, 8'h00);
        step(1'b1, 3'd0, 8'h00, 8'h00);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; op = 3'd0; addr = '0; offset = '0;
        do_reset();
        check("rst_pc", pc_out, 8'h00);
        check("rst_sp", sp, 3'd0);
        check("rst_top", ret_top, 8'h00);
        check("rst_ovf", ovf, 1'b0);
        check("rst_unf", unf, 1'b0);

        for (int i = 0; i < 10; i++) step(1'b1, PC_INC, 8'h00, 8'h00);
        check("inc10", pc_out, 8'h0A);
        step(1'b1, PC_LD, 8'hFE, 8'h00);
        check("ld_fe", pc_out, 8'hFE);
        step(1'b1, PC_INC, 8'h00, 8'h00);
        check("inc_ff", pc_out, 8'hFF);
        step(1'b1, PC_INC, 8'h00, 8'h00);
        check("inc_wrap", pc_out, 8'h00);
        step(1'b1, PC_INC, 8'h00, 8'h00);
        check("inc_01", pc_out, 8'h01);

        step(1'b1, PC_LD, 8'hA7, 8'h00);
        check("ld_a7", pc_out, 8'hA7);
        for (int i = 0; i < 5; i++) step(1'b0, PC_INC, 8'h00, 8'h00);
        check("stall", pc_out, 8'hA7);
        step(1'b1, PC_HOLD, 8'h00, 8'h00);
        check("hold", pc_out, 8'hA7);
        step(1'b1, 3'd6, 8'h00, 8'h00);
        check("rsvd6", pc_out, 8'hA8);
        step(1'b1, 3'd7, 8'h00, 8'h00);
        check("rsvd7", pc_out, 8'hA9);

        step(1'b1, PC_LD, 8'h10, 8'h00);
        step(1'b1, PC_BR, 8'h00, 8'h05);
        check("br_fwd", pc_out, 8'h15);
        step(1'b1, PC_BR, 8'h00, 8'hF0);
        check("br_back", pc_out, 8'h05);
        step(1'b1, PC_LD, 8'hFE, 8'h00);
        step(1'b1, PC_BR, 8'h00, 8'h04);
        check("br_wrap", pc_out, 8'h02);

        step(1'b1, PC_LD, 8'h20, 8'h00);
        step(1'b1, PC_CALL, 8'h40, 8'h00);
        check("call1_pc", pc_out, 8'h40);
        check("call1_sp", sp, 3'd1);
        check("call1_top", ret_top, 8'h21);
        step(1'b1, PC_CALL, 8'h60, 8'h00);
        check("call2_pc", pc_out, 8'h60);
        check("call2_sp", sp, 3'd2);
        check("call2_top", ret_top, 8'h41);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("ret1_pc", pc_out, 8'h41);
        check("ret1_top", ret_top, 8'h21);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("ret2_pc", pc_out, 8'h21);
        check("ret2_sp", sp, 3'd0);
        check("ret2_top", ret_top, 8'h00);

        do_reset();
        step(1'b1, PC_CALL, 8'h10, 8'h00);
        step(1'b1, PC_CALL, 8'h20, 8'h00);
        step(1'b1, PC_CALL, 8'h30, 8'h00);
        step(1'b1, PC_CALL, 8'h40, 8'h00);
        check("c4_sp", sp, 3'd4);
        check("c4_top", ret_top, 8'h31);
        check("c4_ovf", ovf, 1'b0);
        step(1'b1, PC_CALL, 8'h50, 8'h00);
        check("c5_pc", pc_out, 8'h50);
        check("c5_sp", sp, 3'd4);
        check("c5_top", ret_top, 8'h31);
        check("c5_ovf", ovf, 1'b1);
        step(1'b0, PC_RET, 8'h00, 8'h00);
        check("stall_pc", pc_out, 8'h50);
        check("stall_sp", sp, 3'd4);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("r1_pc", pc_out, 8'h31);
        check("r1_sp", sp, 3'd3);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("r2_pc", pc_out, 8'h21);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("r3_pc", pc_out, 8'h11);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("r4_pc", pc_out, 8'h01);
        check("r4_sp", sp, 3'd0);
        check("r4_unf", unf, 1'b0);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("r5_pc", pc_out, 8'h02);
        check("r5_unf", unf, 1'b1);
        check("r5_ovf", ovf, 1'b1);
        check("r5_sp", sp, 3'd0);
        step(1'b1, PC_INC, 8'h00, 8'h00);
        check("post_flag_inc", pc_out, 8'h03);

        do_reset();
        step(1'b1, PC_CALL, 8'h10, 8'h00);
        step(1'b1, PC_CALL, 8'h20, 8'h00);
        check("pre_rst_sp", sp, 3'd2);
        rst = 1'b0;
        step(1'b1, PC_CALL, 8'h77, 8'h00);
        rst = 1'b1;
        check("mid_rst_pc", pc_out, 8'h00);
        check("mid_rst_sp", sp, 3'd0);
        check("mid_rst_top", ret_top, 8'h00);
        check("mid_rst_ovf", ovf, 1'b0);
        check("mid_rst_unf", unf, 1'b0);
        step(1'b1, PC_RET, 8'h00, 8'h00);
        check("after_rst_ret", pc_out, 8'h01);
        check("after_rst_unf", unf, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
